// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// Purpose:
//    SPI master (mode 0, MSB first) for the SPI memory slave. Each accepted
//    request runs one 16-bit frame: 7-bit address, read/write bit, 8 data
//    bits. On read frames the last 8 bits sampled from miso are returned on
//    rdata when the frame completes.
//
// Frame timing (D = CLK_DIV, accept sampled at the edge closing cycle t):
//    t+1            : cs low, mosi = addr[6], busy high      (SETUP, D cycles)
//    t+1+D*(1+2k)   : sclk rises, miso sampled               (SHIFT, 32*D cycles)
//    t+1+D*(2+2k)   : sclk falls, mosi advances
//    t+1+33*D       : HOLD, sclk low, mosi low               (HOLD, D cycles)
//    t+1+34*D       : cs high, done pulse, busy low
//
// Parameters:
//    CLK_DIV  SCLK half-period in clk cycles, 1..255.
//
// Ports:
//    clk      in   system clock, rising edge
//    reset_n  in   synchronous active-low reset
//    start    in   frame request, accepted only while idle
//    rw       in   1 = read, 0 = write (latched on accept)
//    addr     in   [6:0] memory address (latched on accept)
//    wdata    in   [7:0] write data (latched on accept, ignored for reads)
//    busy     out  frame in progress
//    done     out  one-cycle completion pulse
//    rdata    out  [7:0] data of the most recent completed read
//    sclk     out  SPI clock, idles low
//    cs       out  chip select, active low
//    mosi     out  serial data to slave
//    miso     in   serial data from slave
// -----------------------------------------------------------------------------
module spi_master #(
   parameter int unsigned CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       sclk,
   output logic       cs,
   output logic       mosi,
   input  logic       miso
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_SHIFT = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   localparam logic [7:0] LP_HALF_LAST = 8'(CLK_DIV - 1);

   state_t      r_state;
   logic [7:0]  r_hcnt;     // cycle within the current half-period
   logic [4:0]  r_bcnt;     // half-period index within SHIFT, 0..31
   logic [15:0] r_tx;       // outgoing frame, MSB drives mosi
   logic [15:0] r_rx;       // incoming bits, shifted in at the LSB
   logic        r_rw;
   logic        r_busy;
   logic        r_done;
   logic        r_sclk;
   logic        r_cs;
   logic [7:0]  r_rdata;

   logic        w_half_end;
   logic        w_unused_rx;

   assign w_half_end  = (r_hcnt == LP_HALF_LAST);

   // The upper rx bits hold what the slave drove during the address/rw phase;
   // only the data byte is ever returned.
   assign w_unused_rx = ^r_rx[15:8];

   // mosi is the tx MSB itself: after the 16th shift the register is all
   // zeros, which gives mosi=0 through HOLD and IDLE without extra logic.
   assign mosi  = r_tx[15];
   assign sclk  = r_sclk;
   assign cs    = r_cs;
   assign busy  = r_busy;
   assign done  = r_done;
   assign rdata = r_rdata;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_hcnt  <= 8'd0;
         r_bcnt  <= 5'd0;
         r_tx    <= 16'd0;
         r_rx    <= 16'd0;
         r_rw    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sclk  <= 1'b0;
         r_cs    <= 1'b1;
         r_rdata <= 8'd0;
      end else begin
         r_done <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_cs   <= 1'b1;
               r_sclk <= 1'b0;
               if (start) begin
                  // Read frames send zeros in the data phase.
                  r_tx    <= {addr, rw, (rw ? 8'h00 : wdata)};
                  r_rw    <= rw;
                  r_hcnt  <= 8'd0;
                  r_bcnt  <= 5'd0;
                  r_busy  <= 1'b1;
                  r_cs    <= 1'b0;
                  r_state <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (w_half_end) begin
                  // First rising edge: miso is sampled at the same clk edge
                  // that raises sclk.
                  r_hcnt  <= 8'd0;
                  r_sclk  <= 1'b1;
                  r_rx    <= {r_rx[14:0], miso};
                  r_state <= S_SHIFT;
               end else begin
                  r_hcnt <= r_hcnt + 8'd1;
               end
            end

            S_SHIFT: begin
               if (w_half_end) begin
                  r_hcnt <= 8'd0;
                  r_bcnt <= r_bcnt + 5'd1;
                  if (r_bcnt == 5'd31) begin
                     // Last (low) half-period done; sclk is already low.
                     r_state <= S_HOLD;
                  end else if (!r_bcnt[0]) begin
                     // Even half-periods are high: end with a falling edge.
                     r_sclk <= 1'b0;
                     r_tx   <= {r_tx[14:0], 1'b0};
                  end else begin
                     // Odd half-periods are low: end with a rising edge.
                     r_sclk <= 1'b1;
                     r_rx   <= {r_rx[14:0], miso};
                  end
               end else begin
                  r_hcnt <= r_hcnt + 8'd1;
               end
            end

            S_HOLD: begin
               if (w_half_end) begin
                  r_hcnt  <= 8'd0;
                  r_cs    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
                  if (r_rw) begin
                     r_rdata <= r_rx[7:0];
                  end
               end else begin
                  r_hcnt <= r_hcnt + 8'd1;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
